// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Brief    : State encoding and bubble constant shared by all pipe_* stages.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // Stages slice the low CTRL_W bits, so any control width up to 256 works.
    localparam logic [255:0] CTRL_BUBBLE = '0;

    function automatic logic stage_can_accept(input pipe_state_e st);
        return (st != ST_FULL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that sticks at its all-ones value instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// Module   : pipe_skid_stage
// Brief    : Two-entry skid pipeline register with flush and stall counting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 48,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CTRL_W-1:0] c_bubble = CTRL_BUBBLE[CTRL_W-1:0];

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_out_valid;
    logic w_in_xfer;
    logic w_out_xfer;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;
    logic w_stall;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_xfer   = in_valid && r_in_ready;
    assign w_out_xfer  = w_out_valid && out_ready;
    assign w_stall     = w_out_valid && !out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt    = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    case ({w_in_xfer, w_out_xfer})
                        2'b10: begin
                            w_state_nxt = ST_FULL;
                            w_load_skid = 1'b1;
                        end
                        2'b01: w_state_nxt = ST_EMPTY;
                        2'b11: w_load_main_in = 1'b1;
                        default: w_state_nxt = ST_ONE;
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain side can move
                    if (w_out_xfer) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= stage_can_accept(w_state_nxt);
            if (w_load_main_in) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall),
        .count (stall_cnt)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = w_out_valid ? r_main_ctrl : c_bubble;

endmodule

`default_nettype wire

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 48: payload width (rs1/rs2/imm data bundle).
REQ-002 SHALL have parameter CTRL_W, default 16: control-field width (reg_write, mem_*, branch, alu_op, rd …).
REQ-003 SHALL have parameter CNT_W, default 16: stall-counter width.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port flush, input, 1: discard all held entries (branch mispredict).
REQ-007 SHALL have port in_valid, input, 1: upstream offers an entry.
REQ-008 SHALL have port in_ready, output, 1: stage can accept; registered, not combinationally dependent on out_ready.
REQ-009 SHALL have port in_data, input, DATA_W: upstream payload.
REQ-010 SHALL have port in_ctrl, input, CTRL_W: upstream control.
REQ-011 SHALL have port out_valid, output, 1: entry presented downstream.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts.
REQ-013 SHALL have port out_data, output, DATA_W: head payload.
REQ-014 SHALL have port out_ctrl, output, CTRL_W: head control; all-zero whenever out_valid=0 (bubble).
REQ-015 SHALL have port stall_cnt, output, CNT_W: count of backpressure cycles.

Function
REQ-016 SHALL treat a transfer as occurring on a rising edge where valid&&ready are both 1, on each side independently.
REQ-017 SHALL hold at most 2 entries, main and skid registers, with states EMPTY(0), ONE(1), FULL(2).
REQ-018 SHALL drive in_ready=1 in EMPTY and ONE, and 0 in FULL.
REQ-019 SHALL assert out_valid one cycle after an input transfer into EMPTY (latency 1); out_valid=1 in ONE and FULL.
REQ-020 SHALL make transitions: EMPTY+in → ONE; ONE+in+!out → FULL; ONE+!in+out → EMPTY; ONE+in+out → ONE (main reloaded); FULL+out → ONE (skid moves to main); any other combination holds the current state.
REQ-021 SHALL deliver entries strictly in acceptance order, with no loss or duplication.
REQ-022 SHALL keep out_data/out_ctrl stable while out_valid=1 && out_ready=0.
REQ-023 SHALL, on flush, go to EMPTY on the next edge and discard a same-cycle input transfer; flush overrides in/out activity and out_valid=0 the following cycle.
REQ-024 SHALL let out_data hold its last value when out_valid=0; only out_ctrl is forced to zero.
REQ-025 SHALL increment stall_cnt on each edge where out_valid=1 && out_ready=0, saturating at 2^CNT_W−1 with no wrap; flush does not clear it.
REQ-026 SHALL, when flush and a stall condition occur together, count that cycle.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, set state=EMPTY, in_ready=1, out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, and clear the skid register.
REQ-028 SHALL give rst priority over flush and over any transfer, including mid-operation in FULL, and accept nothing on the reset edge.
REQ-029 SHALL accept an input on the first edge after rst deasserts if in_valid=1.

Structure
REQ-030 SHALL take its state encoding (EMPTY/ONE/FULL) and the bubble control constant CTRL_BUBBLE (all-zero) from shared package pipe_pkg, reused by all pipe_* stage registers.
REQ-031 SHALL place the saturating counter in sub-module sat_counter (params WIDTH; ports clk, rst, inc, count).
REQ-032 SHALL have ID/EX, EX/MEM and MEM/WB each instantiate pipe_skid_stage with their own DATA_W/CTRL_W.

Verification
REQ-033 SHALL cover: out_ready=1, push 0x000A,0x000B,0x000C back-to-back → same three out on consecutive cycles starting 1 cycle later, in_ready stays 1.
REQ-034 SHALL cover: out_ready=0, push 0x0011,0x0022 → FULL, in_ready=0 next cycle, third push 0x0033 held off; release out_ready → 0x0011,0x0022,0x0033 in order.
REQ-035 SHALL cover: FULL, then flush=1 with in_valid=1 (0x0044) → next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x0044 never appears.
REQ-036 SHALL cover: CNT_W=4, out_valid held with out_ready=0 for 20 cycles → stall_cnt=15 (saturated), not 4.
REQ-037 SHALL cover: rst=1 while FULL with stall_cnt=7 → next cycle all outputs zero, stall_cnt=0, in_ready=1.
REQ-038 SHALL cover: random valid/ready (50%), 1000 entries → scoreboard shows in-order, lossless delivery, and out_data stable under backpressure.
